// File: rtl/sound_play_ctrl_if.sv
// Register-bus and DMA-request bundle between sound_play_ctrl and its masters.
interface sound_play_ctrl_if;
  logic [15:0] WRADDR;
  logic [3:0]  BYTEEN;
  logic        WREN;
  logic [31:0] WDATA;
  logic [15:0] RDADDR;
  logic        RDEN;
  logic [31:0] RDATA;
  logic        DMA_REQ;
  logic [31:0] DMA_ADDR;
  logic [15:0] DMA_LEN;
  logic        DMA_ACK;
  logic        DMA_DONE;

  modport master (
    output WRADDR, BYTEEN, WREN, WDATA, RDADDR, RDEN,
    input  RDATA,
    input  DMA_REQ, DMA_ADDR, DMA_LEN,
    output DMA_ACK, DMA_DONE
  );

  modport slave (
    input  WRADDR, BYTEEN, WREN, WDATA, RDADDR, RDEN,
    output RDATA,
    output DMA_REQ, DMA_ADDR, DMA_LEN,
    input  DMA_ACK, DMA_DONE
  );
endinterface

// File: rtl/sound_play_ctrl.sv
// Sound playback register block and STOP/PLAY/PAUSE/FLUSH DMA sequencer.
// Optional end-of-data interrupt enabled by defining SOUND_PLAY_IRQ_EN.
module sound_play_ctrl #(
  parameter logic [15:0] C_BASE_ADDR   = 16'h3000,
  parameter int unsigned C_BURST_BYTES = 64,
  parameter int unsigned C_SPACE_WIDTH = 10
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  sound_play_ctrl_if.slave         bus,
  input  logic [C_SPACE_WIDTH-1:0] FIFO_SPACE,
  input  logic                     FIFO_EMPTY,
  output logic                     FIFO_FLUSH,
  input  logic                     SND_UNDER,
  input  logic                     SND_OVER,
  output logic                     SND_RUN,
  output logic [7:0]               SND_VOL
`ifdef SOUND_PLAY_IRQ_EN
  ,
  output logic                     IRQ
`endif
);

  localparam int unsigned BURST_WORDS = C_BURST_BYTES / 4;

  localparam logic [1:0] ST_FLUSH = 2'b00;
  localparam logic [1:0] ST_PLAY  = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_STOP  = 2'b11;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_PLAY  = 2'b01;
  localparam logic [1:0] CMD_PAUSE = 2'b10;
  localparam logic [1:0] CMD_STOP  = 2'b11;

  localparam logic [2:0] OFS_START   = 3'd0;
  localparam logic [2:0] OFS_SIZE    = 3'd1;
  localparam logic [2:0] OFS_VOLUME  = 3'd2;
  localparam logic [2:0] OFS_CONTROL = 3'd3;
  localparam logic [2:0] OFS_STATUS  = 3'd4;

  logic [1:0]  state_q, state_d;
  logic [31:0] start_q, start_d;
  logic [31:0] size_q, size_d;
  logic [7:0]  vol_q, vol_d;
  logic        loop_q, loop_d;
  logic [31:0] cur_addr_q, cur_addr_d;
  logic [31:0] remain_q, remain_d;
  logic        outstanding_q, outstanding_d;
  logic        dma_req_q, dma_req_d;
  logic [31:0] dma_addr_q, dma_addr_d;
  logic [15:0] dma_len_q, dma_len_d;
  logic        flush_q, flush_d;
  logic        run_q, run_d;
  logic        under_q, under_d;
  logic        over_q, over_d;
  logic [31:0] rdata_q, rdata_d;
`ifdef SOUND_PLAY_IRQ_EN
  logic        irq_en_q, irq_en_d;
  logic        eod_q, eod_d;
  logic        irq_q, irq_d;
`endif

  logic        wr_hit_c, rd_hit_c, ctrl_wr_c, space_ok_c, end_of_data_c;
  logic [2:0]  wr_ofs_c, rd_ofs_c;
  logic [1:0]  cmd_c;
  logic        unused_c;

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  assign wr_hit_c  = bus.WREN && (bus.WRADDR[15:5] == C_BASE_ADDR[15:5]);
  assign rd_hit_c  = bus.RDEN && (bus.RDADDR[15:5] == C_BASE_ADDR[15:5]);
  assign wr_ofs_c  = bus.WRADDR[4:2];
  assign rd_ofs_c  = bus.RDADDR[4:2];
  assign ctrl_wr_c = wr_hit_c && (wr_ofs_c == OFS_CONTROL) && bus.BYTEEN[0];
  assign cmd_c     = ctrl_wr_c ? bus.WDATA[1:0] : CMD_NONE;
  assign space_ok_c    = 32'(FIFO_SPACE) >= BURST_WORDS;
  assign end_of_data_c = (remain_q == 32'd0) && !outstanding_q && !dma_req_q;
  assign unused_c      = ^{bus.WRADDR[1:0], bus.RDADDR[1:0]};

  // Next-state: register writes, status events, DMA handshake, then FSM.
  always_comb begin
    state_d       = state_q;
    start_d       = start_q;
    size_d        = size_q;
    vol_d         = vol_q;
    loop_d        = loop_q;
    cur_addr_d    = cur_addr_q;
    remain_d      = remain_q;
    outstanding_d = outstanding_q;
    dma_req_d     = dma_req_q;
    dma_addr_d    = dma_addr_q;
    dma_len_d     = dma_len_q;
    flush_d       = 1'b0;
    under_d       = under_q;
    over_d        = over_q;
    rdata_d       = 32'd0;
`ifdef SOUND_PLAY_IRQ_EN
    irq_en_d      = irq_en_q;
    eod_d         = eod_q;
    irq_d         = eod_q & irq_en_q;
`endif

    if (wr_hit_c) begin
      case (wr_ofs_c)
        OFS_START:  start_d = be_merge(start_q, bus.WDATA, bus.BYTEEN) & ~32'd3;
        OFS_SIZE:   size_d  = be_merge(size_q, bus.WDATA, bus.BYTEEN) & ~32'd3;
        OFS_VOLUME: if (bus.BYTEEN[0]) vol_d = bus.WDATA[7:0];
        OFS_CONTROL: begin
          if (bus.BYTEEN[0]) begin
            loop_d = bus.WDATA[2];
`ifdef SOUND_PLAY_IRQ_EN
            irq_en_d = bus.WDATA[3];
`endif
          end
        end
        OFS_STATUS: begin
          if (bus.BYTEEN[1] && bus.WDATA[8]) under_d = 1'b0;
          if (bus.BYTEEN[1] && bus.WDATA[9]) over_d  = 1'b0;
`ifdef SOUND_PLAY_IRQ_EN
          if (bus.BYTEEN[2] && bus.WDATA[16]) eod_d = 1'b0;
`endif
        end
        default: ;
      endcase
    end

    // Events override a same-cycle clear.
    if (SND_UNDER) under_d = 1'b1;
    if (SND_OVER)  over_d  = 1'b1;

    if (bus.DMA_DONE) outstanding_d = 1'b0;
    if (bus.DMA_ACK && dma_req_q) begin
      dma_req_d     = 1'b0;
      cur_addr_d    = cur_addr_q + 32'(dma_len_q);
      remain_d      = remain_q - 32'(dma_len_q);
      outstanding_d = 1'b1;
    end

    case (state_q)
      ST_STOP: begin
        if (cmd_c == CMD_PLAY && size_q != 32'd0) begin
          cur_addr_d = start_q;
          remain_d   = size_q;
          state_d    = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (cmd_c == CMD_PAUSE) begin
          state_d = ST_PAUSE;
        end else if (cmd_c == CMD_STOP) begin
          state_d = ST_FLUSH;
        end else if (end_of_data_c) begin
`ifdef SOUND_PLAY_IRQ_EN
          eod_d = 1'b1;
`endif
          if (loop_q) begin
            cur_addr_d = start_q;
            remain_d   = size_q;
          end else if (FIFO_EMPTY) begin
            state_d = ST_STOP;
          end
        end else if (!dma_req_q && !outstanding_q && space_ok_c) begin
          dma_req_d  = 1'b1;
          dma_addr_d = cur_addr_q;
          dma_len_d  = (remain_q < C_BURST_BYTES) ? remain_q[15:0] : 16'(C_BURST_BYTES);
        end
      end
      ST_PAUSE: begin
        if (cmd_c == CMD_PLAY) begin
          state_d = ST_PLAY;
        end else if (cmd_c == CMD_STOP) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // Handshake results of this cycle count, so the flush follows DONE directly.
        if (!dma_req_d && !outstanding_d) begin
          flush_d = 1'b1;
          state_d = ST_STOP;
        end
      end
      default: state_d = ST_STOP;
    endcase

    run_d = (state_d == ST_PLAY);

    if (rd_hit_c) begin
      case (rd_ofs_c)
        OFS_START:   rdata_d = start_q;
        OFS_SIZE:    rdata_d = size_q;
        OFS_VOLUME:  rdata_d = {24'd0, vol_q};
`ifdef SOUND_PLAY_IRQ_EN
        OFS_CONTROL: rdata_d = {28'd0, irq_en_q, loop_q, state_q};
        OFS_STATUS:  rdata_d = {15'd0, eod_q, 6'd0, over_q, under_q, 6'd0, dma_req_q, outstanding_q};
`else
        OFS_CONTROL: rdata_d = {29'd0, loop_q, state_q};
        OFS_STATUS:  rdata_d = {22'd0, over_q, under_q, 6'd0, dma_req_q, outstanding_q};
`endif
        default:     rdata_d = 32'd0;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q       <= ST_STOP;
      start_q       <= 32'd0;
      size_q        <= 32'd0;
      vol_q         <= 8'd0;
      loop_q        <= 1'b0;
      cur_addr_q    <= 32'd0;
      remain_q      <= 32'd0;
      outstanding_q <= 1'b0;
      dma_req_q     <= 1'b0;
      dma_addr_q    <= 32'd0;
      dma_len_q     <= 16'd0;
      flush_q       <= 1'b0;
      run_q         <= 1'b0;
      under_q       <= 1'b0;
      over_q        <= 1'b0;
      rdata_q       <= 32'd0;
`ifdef SOUND_PLAY_IRQ_EN
      irq_en_q      <= 1'b0;
      eod_q         <= 1'b0;
      irq_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      start_q       <= start_d;
      size_q        <= size_d;
      vol_q         <= vol_d;
      loop_q        <= loop_d;
      cur_addr_q    <= cur_addr_d;
      remain_q      <= remain_d;
      outstanding_q <= outstanding_d;
      dma_req_q     <= dma_req_d;
      dma_addr_q    <= dma_addr_d;
      dma_len_q     <= dma_len_d;
      flush_q       <= flush_d;
      run_q         <= run_d;
      under_q       <= under_d;
      over_q        <= over_d;
      rdata_q       <= rdata_d;
`ifdef SOUND_PLAY_IRQ_EN
      irq_en_q      <= irq_en_d;
      eod_q         <= eod_d;
      irq_q         <= irq_d;
`endif
    end
  end

  assign bus.RDATA    = rdata_q;
  assign bus.DMA_REQ  = dma_req_q;
  assign bus.DMA_ADDR = dma_addr_q;
  assign bus.DMA_LEN  = dma_len_q;
  assign FIFO_FLUSH   = flush_q;
  assign SND_RUN      = run_q;
  assign SND_VOL      = vol_q;
`ifdef SOUND_PLAY_IRQ_EN
  assign IRQ          = irq_q;
`endif

endmodule

// File: tb/tb_sound_play_ctrl.sv
// Self-checking bench for sound_play_ctrl: DMA responder with request scoreboard plus
// per-scenario register and control checks.
module tb_sound_play_ctrl;

  localparam int unsigned SPW = 10;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] len;
  } req_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [SPW-1:0] fifo_space;
  logic           fifo_empty, fifo_flush, snd_under, snd_over, snd_run;
  logic [7:0]     snd_vol;
`ifdef SOUND_PLAY_IRQ_EN
  logic           irq;
`endif

  sound_play_ctrl_if bus ();

  sound_play_ctrl #(
    .C_BASE_ADDR  (16'h3000),
    .C_BURST_BYTES(64),
    .C_SPACE_WIDTH(SPW)
  ) dut (
    .ACLK      (clk),
    .ARESET    (rst),
    .bus       (bus),
    .FIFO_SPACE(fifo_space),
    .FIFO_EMPTY(fifo_empty),
    .FIFO_FLUSH(fifo_flush),
    .SND_UNDER (snd_under),
    .SND_OVER  (snd_over),
    .SND_RUN   (snd_run),
    .SND_VOL   (snd_vol)
`ifdef SOUND_PLAY_IRQ_EN
    ,
    .IRQ       (irq)
`endif
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  req_t sb[$];
  int   served = 0;
  bit   hold_ack = 1'b0;
  bit   done_pend = 1'b0;
  int   done_cnt = 0;
  int   done_dly = 3;
  int   done_cycle = -1;
  int   flush_cnt = 0;
  int   flush_cycle = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // DMA read-master model: acks each request, compares it to the scoreboard, returns DONE later.
  initial begin
    req_t exp;
    bus.DMA_ACK  = 1'b0;
    bus.DMA_DONE = 1'b0;
    forever begin
      @(negedge clk);
      bus.DMA_ACK  = 1'b0;
      bus.DMA_DONE = 1'b0;
      if (done_pend) begin
        if (done_cnt == 0) begin
          bus.DMA_DONE = 1'b1;
          done_pend    = 1'b0;
          done_cycle   = cyc;
        end else begin
          done_cnt--;
        end
      end
      if (bus.DMA_REQ && !hold_ack && !done_pend && !rst) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL dma_unexpected: got addr %h len %0d, required no request", bus.DMA_ADDR, bus.DMA_LEN);
        end else begin
          exp = sb.pop_front();
          if (bus.DMA_ADDR !== exp.addr || bus.DMA_LEN !== exp.len) begin
            errors++;
            $display("FAIL dma_req: got addr %h len %0d, required addr %h len %0d",
                     bus.DMA_ADDR, bus.DMA_LEN, exp.addr, exp.len);
          end
        end
        bus.DMA_ACK = 1'b1;
        served++;
        done_pend = 1'b1;
        done_cnt  = done_dly;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (fifo_flush) begin
        flush_cnt++;
        flush_cycle = cyc;
      end
    end
  end

  task automatic reg_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    bus.WRADDR = a; bus.WDATA = d; bus.BYTEEN = be; bus.WREN = 1'b1;
    @(negedge clk);
    bus.WREN = 1'b0;
  endtask

  task automatic reg_read(input logic [15:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.RDADDR = a; bus.RDEN = 1'b1;
    @(negedge clk);
    bus.RDEN = 1'b0;
    d = bus.RDATA;
  endtask

  task automatic wait_idle(input int budget, output bit timed_out);
    int n;
    n = 0;
    timed_out = 1'b0;
    while (sb.size() != 0 || done_pend || bus.DMA_REQ) begin
      @(negedge clk);
      n++;
      if (n > budget) begin
        timed_out = 1'b1;
        break;
      end
    end
  endtask

  task automatic push_bursts(input logic [31:0] base, input int n, input logic [15:0] len);
    req_t r;
    for (int i = 0; i < n; i++) begin
      r.addr = base + 32'(i * 64);
      r.len  = len;
      sb.push_back(r);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.DMA_REQ !== 1'b0 || snd_run !== 1'b0 || fifo_flush !== 1'b0 || snd_vol !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got req %b run %b flush %b vol %h, required 0 0 0 00",
               bus.DMA_REQ, snd_run, fifo_flush, snd_vol);
    end
    reg_read(16'h300C, d);
    checks++;
    if (d !== 32'h3) begin errors++; $display("FAIL reset_control: got %h required %h", d, 32'h3); end
    reg_read(16'h3010, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_status: got %h required %h", d, 32'h0); end
  endtask

  task automatic test_full_play();
    logic [31:0] d;
    bit to;
    int base_served, base_flush;
    base_served = served;
    base_flush  = flush_cnt;
    fifo_empty  = 1'b0;
    reg_write(16'h3000, 32'h0, 4'hF);
    reg_write(16'h3004, 32'd4096, 4'hF);
    reg_write(16'h3008, 32'hFF, 4'hF);
    push_bursts(32'h0, 64, 16'd64);
    reg_write(16'h300C, 32'h1, 4'hF);
    wait_idle(5000, to);
    checks++;
    if (to) begin errors++; $display("FAIL full_timeout: got %0d queued required 0", sb.size()); end
    checks++;
    if (served - base_served !== 64) begin
      errors++; $display("FAIL full_count: got %0d required 64", served - base_served);
    end
    checks++;
    if (snd_vol !== 8'hFF || snd_run !== 1'b1) begin
      errors++; $display("FAIL full_vol_run: got vol %h run %b required ff 1", snd_vol, snd_run);
    end
    repeat (10) @(negedge clk);
    reg_read(16'h300C, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL full_wait_empty: got %h required %h", d, 32'h1); end
    fifo_empty = 1'b1;
    repeat (3) @(negedge clk);
    reg_read(16'h300C, d);
    checks++;
    if (d !== 32'h3) begin errors++; $display("FAIL full_stop: got %h required %h", d, 32'h3); end
    checks++;
    if (flush_cnt !== base_flush || snd_run !== 1'b0) begin
      errors++; $display("FAIL full_noflush: got flushes %0d run %b required 0 0", flush_cnt - base_flush, snd_run);
    end
  endtask

  task automatic test_short();
    logic [31:0] d;
    bit to;
    req_t r;
    reg_write(16'h3004, 32'd100, 4'hF);
    r.addr = 32'h0;  r.len = 16'd64; sb.push_back(r);
    r.addr = 32'd64; r.len = 16'd36; sb.push_back(r);
    reg_write(16'h300C, 32'h1, 4'hF);
    wait_idle(500, to);
    checks++;
    if (to) begin errors++; $display("FAIL short_timeout: got %0d queued required 0", sb.size()); end
    repeat (3) @(negedge clk);
    reg_read(16'h300C, d);
    checks++;
    if (d !== 32'h3) begin errors++; $display("FAIL short_control: got %h required %h", d, 32'h3); end
  endtask

  task automatic test_pause();
    logic [31:0] d;
    bit to;
    int base_served;
    base_served = served;
    reg_write(16'h3000, 32'h1000, 4'hF);
    reg_write(16'h3004, 32'd256, 4'hF);
    push_bursts(32'h1000, 4, 16'd64);
    hold_ack = 1'b1;
    reg_write(16'h300C, 32'h1, 4'hF);
    for (int n = 0; n < 50 && !bus.DMA_REQ; n++) @(negedge clk);
    checks++;
    if (bus.DMA_REQ !== 1'b1) begin errors++; $display("FAIL pause_req_seen: got %b required 1", bus.DMA_REQ); end
    reg_write(16'h300C, 32'h2, 4'hF);
    repeat (4) @(negedge clk);
    checks++;
    if (bus.DMA_REQ !== 1'b1 || snd_run !== 1'b0) begin
      errors++; $display("FAIL pause_hold: got req %b run %b required 1 0", bus.DMA_REQ, snd_run);
    end
    reg_read(16'h300C, d);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL pause_control: got %h required %h", d, 32'h2); end
    hold_ack = 1'b0;
    repeat (25) @(negedge clk);
    checks++;
    if (served - base_served !== 1 || bus.DMA_REQ !== 1'b0) begin
      errors++; $display("FAIL pause_no_issue: got %0d bursts req %b required 1 0", served - base_served, bus.DMA_REQ);
    end
    reg_write(16'h300C, 32'h1, 4'hF);
    wait_idle(500, to);
    checks++;
    if (to || served - base_served !== 4) begin
      errors++; $display("FAIL pause_resume: got %0d bursts required 4", served - base_served);
    end
    repeat (3) @(negedge clk);
    reg_read(16'h300C, d);
    checks++;
    if (d !== 32'h3) begin errors++; $display("FAIL pause_end: got %h required %h", d, 32'h3); end
  endtask

  task automatic test_loop_stop();
    logic [31:0] d;
    bit run_drop;
    int base_served, base_flush;
    base_served = served;
    base_flush  = flush_cnt;
    run_drop    = 1'b0;
    done_dly    = 8;
    reg_write(16'h3000, 32'h0, 4'hF);
    reg_write(16'h3004, 32'd256, 4'hF);
    push_bursts(32'h0, 4, 16'd64);
    push_bursts(32'h0, 2, 16'd64);
    reg_write(16'h300C, 32'h5, 4'hF);
    for (int n = 0; n < 1000 && served < base_served + 6; n++) begin
      @(negedge clk);
      if (snd_run !== 1'b1) run_drop = 1'b1;
    end
    checks++;
    if (run_drop || served - base_served !== 6) begin
      errors++; $display("FAIL loop_run: got drop %b bursts %0d required 0 6", run_drop, served - base_served);
    end
    reg_write(16'h300C, 32'h3, 4'hF);
    for (int n = 0; n < 100 && flush_cnt == base_flush; n++) @(negedge clk);
    checks++;
    if (flush_cycle !== done_cycle + 1) begin
      errors++; $display("FAIL stop_flush_timing: got cycle %0d required %0d", flush_cycle, done_cycle + 1);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (flush_cnt - base_flush !== 1 || snd_run !== 1'b0 || sb.size() !== 0) begin
      errors++; $display("FAIL stop_flush_once: got flushes %0d run %b queued %0d required 1 0 0",
                         flush_cnt - base_flush, snd_run, sb.size());
    end
    reg_read(16'h300C, d);
    checks++;
    if (d !== 32'h3) begin errors++; $display("FAIL stop_control: got %h required %h", d, 32'h3); end
    done_dly = 3;
  endtask

  task automatic test_status();
    logic [31:0] d;
    reg_write(16'h3010, 32'h0001_0300, 4'hF);
    @(negedge clk); snd_under = 1'b1;
    @(negedge clk); snd_under = 1'b0;
    reg_read(16'h3010, d);
    checks++;
    if (d !== 32'h100) begin errors++; $display("FAIL under_sticky: got %h required %h", d, 32'h100); end
    @(negedge clk);
    bus.WRADDR = 16'h3010; bus.WDATA = 32'h100; bus.BYTEEN = 4'hF; bus.WREN = 1'b1; snd_under = 1'b1;
    @(negedge clk);
    bus.WREN = 1'b0; snd_under = 1'b0;
    reg_read(16'h3010, d);
    checks++;
    if (d !== 32'h100) begin errors++; $display("FAIL under_event_wins: got %h required %h", d, 32'h100); end
    reg_write(16'h3010, 32'h100, 4'hF);
    reg_read(16'h3010, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL under_clear: got %h required %h", d, 32'h0); end
    @(negedge clk); snd_over = 1'b1;
    @(negedge clk); snd_over = 1'b0;
    reg_read(16'h3010, d);
    checks++;
    if (d !== 32'h200) begin errors++; $display("FAIL over_sticky: got %h required %h", d, 32'h200); end
    reg_write(16'h3010, 32'h200, 4'hF);
    reg_write(16'h3000, 32'h1234_5677, 4'hF);
    reg_write(16'h3000, 32'hFFFF_FFFF, 4'h1);
    reg_read(16'h3000, d);
    checks++;
    if (d !== 32'h1234_56FC) begin errors++; $display("FAIL start_byteen: got %h required %h", d, 32'h1234_56FC); end
    reg_write(16'h3008, 32'hA5, 4'h1);
    reg_read(16'h3008, d);
    checks++;
    if (d !== 32'hA5 || snd_vol !== 8'hA5) begin
      errors++; $display("FAIL volume: got %h vol %h required a5", d, snd_vol);
    end
    reg_read(16'h3014, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL unmapped_3014: got %h required %h", d, 32'h0); end
    reg_read(16'h3020, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL miss_3020: got %h required %h", d, 32'h0); end
    @(negedge clk);
    checks++;
    if (bus.RDATA !== 32'h0) begin errors++; $display("FAIL rdata_idle: got %h required %h", bus.RDATA, 32'h0); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    req_t r;
    int base_served;
    reg_write(16'h3000, 32'h2000, 4'hF);
    reg_write(16'h3004, 32'd256, 4'hF);
    r.addr = 32'h2000; r.len = 16'd64; sb.push_back(r);
    hold_ack = 1'b1;
    reg_write(16'h300C, 32'h1, 4'hF);
    for (int n = 0; n < 50 && !bus.DMA_REQ; n++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.DMA_REQ !== 1'b0 || snd_run !== 1'b0) begin
      errors++; $display("FAIL rst_mid_req: got req %b run %b required 0 0", bus.DMA_REQ, snd_run);
    end
    sb.delete();
    hold_ack = 1'b0;
    reg_read(16'h300C, d);
    checks++;
    if (d !== 32'h3) begin errors++; $display("FAIL rst_mid_state: got %h required %h", d, 32'h3); end
    reg_read(16'h3004, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL rst_mid_size: got %h required %h", d, 32'h0); end

    done_dly = 12;
    base_served = served;
    reg_write(16'h3000, 32'h2000, 4'hF);
    reg_write(16'h3004, 32'd256, 4'hF);
    sb.push_back(r);
    reg_write(16'h300C, 32'h1, 4'hF);
    for (int n = 0; n < 50 && served == base_served; n++) @(negedge clk);
    reg_read(16'h3010, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL outstanding_set: got %h required %h", d, 32'h1); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    sb.delete();
    for (int n = 0; n < 50 && done_pend; n++) @(negedge clk);
    repeat (2) @(negedge clk);
    reg_read(16'h3010, d);
    checks++;
    if (d !== 32'h0 || done_pend) begin
      errors++; $display("FAIL done_after_reset: got %h pending %b required 0 0", d, done_pend);
    end
    done_dly = 3;
  endtask

  initial begin
    rst = 1'b1;
    bus.WRADDR = 16'h0; bus.WDATA = 32'h0; bus.BYTEEN = 4'h0; bus.WREN = 1'b0;
    bus.RDADDR = 16'h0; bus.RDEN = 1'b0;
    fifo_space = SPW'(512);
    fifo_empty = 1'b1;
    snd_under  = 1'b0;
    snd_over   = 1'b0;
    test_reset();
    test_full_play();
    test_short();
    test_pause();
    test_loop_stop();
    test_status();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
